// File: rtl/imm_pkg.sv
// Shared immediate-mode encodings; also consumed by the decoder.
package imm_pkg;
  localparam logic [1:0] MODE_ZEXT     = 2'b00;
  localparam logic [1:0] MODE_SEXT     = 2'b01;
  localparam logic [1:0] MODE_SEXT_SHL = 2'b10;
  localparam logic [1:0] MODE_HIGH     = 2'b11;
endpackage

// File: rtl/imm_extend_core.sv
// Pure combinational immediate extension: zero, sign, sign+shift, or high placement.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int SHIFT = 1
) (
  input  logic [IN_W-1:0]  din,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] word
);
  logic [OUT_W-1:0]      zext, sext, shl, high;
  logic [IN_W+OUT_W-1:0] hi_wide;

  always_comb begin
    zext    = OUT_W'(din);
    sext    = OUT_W'($signed(din));
    shl     = sext << SHIFT;
    // Parking din above OUT_W zeros and shifting down leaves it left-justified.
    hi_wide = {din, {OUT_W{1'b0}}} >> IN_W;
    high    = hi_wide[OUT_W-1:0];
    case (mode)
      MODE_ZEXT:     word = zext;
      MODE_SEXT:     word = sext;
      MODE_SEXT_SHL: word = shl;
      default:       word = high;
    endcase
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage: output register plus one skid entry,
// valid/ready on both sides, in_ready driven purely from flops.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             dout_neg
);
  if (IN_W < 1 || IN_W > OUT_W || SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_params
    $error("imm_extend_pipe: illegal IN_W/OUT_W/SHIFT combination");
  end

  logic [OUT_W-1:0] ext_word;
  logic [OUT_W-1:0] oreg_q, oreg_d, skid_q, skid_d;
  logic             oval_q, oval_d, sval_q, sval_d;
  logic             accept, drain;

  imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_core (
    .din  (din),
    .mode (mode),
    .word (ext_word)
  );

  assign in_ready = !sval_q;
  assign accept   = in_valid && in_ready;
  assign drain    = oval_q && out_ready;

  always_comb begin
    oreg_d = oreg_q;
    oval_d = oval_q;
    skid_d = skid_q;
    sval_d = sval_q;
    if (drain) begin
      // in_ready is low whenever the skid holds data, so accept and
      // skid-refill never coincide.
      if (sval_q) begin
        oreg_d = skid_q;
        sval_d = 1'b0;
      end else if (accept) begin
        oreg_d = ext_word;
      end else begin
        oval_d = 1'b0;
      end
    end else if (!oval_q) begin
      if (accept) begin
        oreg_d = ext_word;
        oval_d = 1'b1;
      end
    end else if (accept) begin
      skid_d = ext_word;
      sval_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_q <= '0;
      oval_q <= 1'b0;
      skid_q <= '0;
      sval_q <= 1'b0;
    end else begin
      oreg_q <= oreg_d;
      oval_q <= oval_d;
      skid_q <= skid_d;
      sval_q <= sval_d;
    end
  end

  assign out_valid = oval_q;
  assign dout      = oreg_q;
  assign dout_neg  = oreg_q[OUT_W-1];
endmodule
